// File: rtl/rgb_csc_pkg.sv
// rgb_csc_pkg: shared FSM states, conversion coefficients and frame defaults
// for the RGB colour-space conversion and write-back stage.
package rgb_csc_pkg;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;
    localparam int C_Y  = 76284;
    localparam int C_RV = 104595;
    localparam int C_GU = 25624;
    localparam int C_GV = 53281;
    localparam int C_BU = 132251;
    localparam int Y_OFF = 16;
    localparam int C_OFF = 128;
    localparam logic [17:0] DEF_RGB_BASE = 18'd146944;
    localparam int DEF_NUM_PIXELS = 76800;
    function automatic logic [7:0] clip8(input logic signed [31:0] x);
        return (x < 0) ? 8'd0 : (x > 255) ? 8'd255 : x[7:0];
    endfunction
endpackage

// File: rtl/csc_pipe.sv
// csc_pipe: two-stage YUV to RGB datapath; stage 1 registers the products,
// stage 2 registers the summed, floored and clipped components.
module csc_pipe import rgb_csc_pkg::*; (
    input  logic       clock_50,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] y,
    input  logic [7:0] u,
    input  logic [7:0] v,
    output logic       out_valid,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b
);
    logic signed [31:0] ys, us, vs, p_y, p_rv, p_gu, p_gv, p_bu;
    logic v1;
    assign ys = $signed({24'd0, y}) - Y_OFF;
    assign us = $signed({24'd0, u}) - C_OFF;
    assign vs = $signed({24'd0, v}) - C_OFF;
    always_ff @(posedge clock_50) begin
        if (reset) begin
            v1 <= 1'b0;
            out_valid <= 1'b0;
            {p_y, p_rv, p_gu, p_gv, p_bu} <= '0;
            {r, g, b} <= '0;
        end else begin
            v1 <= in_valid;
            p_y <= ys * C_Y;
            p_rv <= vs * C_RV;
            p_gu <= us * C_GU;
            p_gv <= vs * C_GV;
            p_bu <= us * C_BU;
            out_valid <= v1;
            r <= clip8((p_y + p_rv) >>> 16);
            g <= clip8((p_y - p_gu - p_gv) >>> 16);
            b <= clip8((p_y + p_bu) >>> 16);
        end
    end
endmodule

// File: rtl/rgb_csc_writer.sv
// rgb_csc_writer: converts a raster YUV frame to RGB, packs pixel pairs into
// three 16-bit words and streams them to consecutive SRAM addresses.
module rgb_csc_writer import rgb_csc_pkg::*; #(
    parameter logic [17:0] RGB_BASE   = DEF_RGB_BASE,
    parameter int          NUM_PIXELS = DEF_NUM_PIXELS,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        Clock_50,
    input  logic        Reset,
    input  logic        start,
    input  logic        pix_valid,
    input  logic [7:0]  pix_Y,
    input  logic [7:0]  pix_U,
    input  logic [7:0]  pix_V,
    output logic        pix_ready,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic        done
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int FCW = PW + 1;
    localparam int CW = $clog2(NUM_PIXELS + 1);
    localparam logic [17:0] WORDS = 18'(3 * NUM_PIXELS / 2);

    state_t state, next_state;
    logic [CW-1:0] pix_count;
    logic [17:0] word_count;
    logic toggle, accept, pop, v2;
    logic [7:0] b0, r, g, b;
    logic [1:0] push_n;
    logic [15:0] w0, w1;
    logic [15:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [FCW-1:0] fifo_count;

    // Admit a pixel only while the FIFO has room for everything still in flight
    assign pix_ready = (state == S_RUN) && (fifo_count <= FCW'(FIFO_DEPTH - 5));
    assign accept = pix_valid && pix_ready;
    assign pop = fifo_count != '0;
    assign done = state == S_DONE;

    csc_pipe u_pipe (
        .clock_50(Clock_50), .reset(Reset), .in_valid(accept),
        .y(pix_Y), .u(pix_U), .v(pix_V),
        .out_valid(v2), .r(r), .g(g), .b(b)
    );

    always_comb begin
        push_n = v2 ? (toggle ? 2'd2 : 2'd1) : 2'd0;
        w0 = toggle ? {b0, r} : {r, g};
        w1 = {g, b};
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  next_state = start ? S_RUN : S_IDLE;
            S_RUN:   next_state = (accept && pix_count == CW'(NUM_PIXELS - 1)) ? S_FLUSH : S_RUN;
            S_FLUSH: next_state = (word_count == WORDS) ? S_DONE : S_FLUSH;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock_50) begin
        if (push_n != 2'd0) mem[wr_ptr] <= w0;
        if (push_n == 2'd2) mem[wr_ptr + 1'b1] <= w1;
    end

    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            state <= S_IDLE;
            pix_count <= '0;
            word_count <= '0;
            toggle <= 1'b0;
            b0 <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            fifo_count <= '0;
            SRAM_we_n <= 1'b1;
            SRAM_address <= '0;
            SRAM_write_data <= '0;
        end else begin
            state <= next_state;
            if (state == S_IDLE && start) begin
                pix_count <= '0;
                word_count <= '0;
                toggle <= 1'b0;
            end else begin
                if (accept) pix_count <= pix_count + 1'b1;
                if (v2) toggle <= !toggle;
                if (v2 && !toggle) b0 <= b;
                if (pop) word_count <= word_count + 1'b1;
            end
            wr_ptr <= wr_ptr + PW'(push_n);
            rd_ptr <= rd_ptr + PW'(pop);
            fifo_count <= fifo_count + FCW'(push_n) - FCW'(pop);
            SRAM_we_n <= !pop;
            if (pop) begin
                SRAM_address <= RGB_BASE + word_count;
                SRAM_write_data <= mem[rd_ptr];
            end
        end
    end
endmodule
